muldiv_unit: RTL and testbench

- Iterative multiply/divide unit that produces the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the execute-stage ALU. The ALU's MFHI/MFLO path consumes the hi/lo outputs of this block.
- Multi-cycle with a busy/done handshake. Hazard logic stalls MFHI/MFLO and any new muldiv op while busy=1.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_unit.sv | 105 ++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and the two's-complement helper for muldiv_unit
// Contents: muldiv_op_t (MULT/MULTU/DIV/DIVU/MTHI/MTLO), muldiv_state_t (IDLE/CALC/FIX),
//           cneg() conditional negate usable at any width up to MAX_W bits.
package muldiv_pkg;
    // Negation modulo 2^n equals the low n bits of negation modulo 2^MAX_W,
    // so callers zero-extend into cneg and truncate the result back to their width.
    localparam int MAX_W = 128;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } muldiv_op_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;
    function automatic logic [MAX_W-1:0] cneg(input logic [MAX_W-1:0] x, input logic s);
        return s ? (~x + MAX_W'(1)) : x;
    endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
// Ports: clk; reset_n (synchronous, active-low); start/op/a/b request (sampled when idle);
//        cancel abandons an in-flight op; busy/done handshake; hi/lo result registers.
// Build option: MULDIV_EARLY_OUT_EN ends multiplies as soon as the remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    muldiv_state_t    state;
    logic [CW-1:0]    count;
    logic [W2-1:0]    acc, md, sh, acc_step;
    logic [WIDTH-1:0] mr, abs_a, abs_b;
    logic [WIDTH:0]   diff;
    logic             div_q, neg_q, neg_r, sa, sb, last;
    assign busy  = state != IDLE;
    // Signed ops have op[0]=0; the unsigned variants never take magnitudes.
    assign sa    = a[WIDTH-1] & ~op[0];
    assign sb    = b[WIDTH-1] & ~op[0];
    assign abs_a = WIDTH'(cneg(MAX_W'(a), sa));
    assign abs_b = WIDTH'(cneg(MAX_W'(b), sb));
    // Divide: acc = {remainder, dividend/quotient}. The remainder's top bit is kept
    // in diff so a shifted remainder of WIDTH+1 bits is compared correctly.
    // Multiply: acc accumulates md (multiplicand shifted left) for each set bit of mr.
    assign sh       = {acc[W2-2:0], 1'b0};
    assign diff     = {acc[W2-1], sh[W2-1:WIDTH]} - {1'b0, md[WIDTH-1:0]};
    assign acc_step = div_q ? (diff[WIDTH] ? sh : {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1})
                            : (mr[0] ? acc + md : acc);
`ifdef MULDIV_EARLY_OUT_EN
    assign last = count == CW'(1) || (!div_q && mr[WIDTH-1:1] == '0);
`else
    assign last = count == CW'(1);
`endif
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            count <= '0;
            acc   <= '0;
            md    <= '0;
            mr    <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && cancel) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start && !cancel) begin
                        if (!op[2]) begin
                            state <= CALC;
                            count <= CW'(WIDTH);
                            div_q <= op[1];
                            neg_q <= sa ^ sb;
                            neg_r <= sa;
                            acc   <= op[1] ? W2'(abs_a) : '0;
                            md    <= W2'(op[1] ? abs_b : abs_a);
                            mr    <= abs_b;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                    CALC: begin
                        acc   <= acc_step;
                        md    <= div_q ? md : md << 1;
                        mr    <= mr >> 1;
                        count <= count - CW'(1);
                        state <= last ? FIX : CALC;
                    end
                    FIX: begin
                        if (div_q) begin
                            lo <= WIDTH'(cneg(MAX_W'(acc[WIDTH-1:0]), neg_q));
                            hi <= WIDTH'(cneg(MAX_W'(acc[W2-1:WIDTH]), neg_r));
                        end else begin
                            {hi, lo} <= W2'(cneg(MAX_W'(acc), neg_q));
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [2:0]  T_OP [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2};
    localparam logic [31:0] T_A  [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h7,
                                         32'h12345678, 32'hFFFFFFFB, 32'h80000000};
    localparam logic [31:0] T_B  [7] = '{32'h7, 32'hFFFFFFFF, 32'h2, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF};
    localparam logic [31:0] T_HI [7] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1,
                                         32'h12345678, 32'hFFFFFFFB, 32'h0};
    localparam logic [31:0] T_LO [7] = '{32'hFFFFFFEB, 32'h1, 32'hFFFFFFFD, 32'h3,
                                         32'hFFFFFFFF, 32'h1, 32'h80000000};
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, cancel = 1'b0;
    logic [2:0] op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done;
    logic [W-1:0] hi, lo;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // Returns {hi, lo} after the op, from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        case (o)
            3'd0: return 64'(sx * sy);
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 0) return {x, x[31] ? 32'd1 : 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            3'd4: return {x, exp_lo};
            3'd5: return {exp_hi, x};
            default: return {exp_hi, exp_lo};
        endcase
    endfunction
    function automatic bit lat_ok(input logic [2:0] o, input int lat);
`ifdef MULDIV_EARLY_OUT_EN
        return o[1] ? lat == W + 2 : (lat >= 3 && lat <= W + 2);
`else
        return o[1] | ~o[1] ? lat == W + 2 : 1'b0;
`endif
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    // Called in cycle n0; returns the cycle number in which done is seen (0 on timeout).
    task automatic wait_done(input int n0, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        for (int n = n0; n < n0 + 100 && lat == 0; n++) begin
            if (done === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                step();
            end
        end
    endtask
    task automatic test_reset();
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    endtask
    task automatic test_mul_div();
        int lat;
        bit bok;
        for (int i = 0; i < 7; i++) begin
            issue(T_OP[i], T_A[i], T_B[i]);
            wait_done(1, lat, bok);
            checks++; if (!lat_ok(T_OP[i], lat)) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, W + 2); end
            checks++; if (!bok) begin errors++; $display("FAIL dir%0d_busy got busy not high exactly until done want busy=1 until done", i); end
            checks++; if (hi !== T_HI[i]) begin errors++; $display("FAIL dir%0d_hi got %h want %h", i, hi, T_HI[i]); end
            checks++; if (lo !== T_LO[i]) begin errors++; $display("FAIL dir%0d_lo got %h want %h", i, lo, T_LO[i]); end
            exp_hi = T_HI[i];
            exp_lo = T_LO[i];
            step();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got done=%b busy=%b want 0 0", i, done, busy); end
        end
    endtask
    task automatic test_mthi_mtlo();
        issue(3'd4, 32'hDEADBEEF, 32'h0);
        checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_hi got %h want deadbeef", hi); end
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL mthi_lo got %h want %h", lo, exp_lo); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_hs got busy=%b done=%b want 0 0", busy, done); end
        exp_hi = 32'hDEADBEEF;
        issue(3'd5, 32'h0BADF00D, 32'h0);
        checks++; if (lo !== 32'h0BADF00D || hi !== exp_hi) begin errors++; $display("FAIL mtlo got hi=%h lo=%h want %h 0badf00d", hi, lo, exp_hi); end
        exp_lo = 32'h0BADF00D;
    endtask
    task automatic test_back_to_back();
        int lat;
        bit bok, quiet;
        logic [63:0] e;
        e = model(3'd1, 32'h0000FFFF, 32'h80000001);
        issue(3'd1, 32'h0000FFFF, 32'h80000001);
        for (int n = 1; n < 5; n++) step();
        op = 3'd1; a = 32'd3; b = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(6, lat, bok);
        checks++; if (lat != W + 2 || !bok) begin errors++; $display("FAIL b2b_latency got %0d busy_ok=%b want %0d 1", lat, bok, W + 2); end
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL b2b_result got %h%h want %h", hi, lo, e); end
        {exp_hi, exp_lo} = e;
        quiet = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL b2b_not_queued got activity after done want idle"); end
    endtask
    task automatic test_cancel();
        bit quiet;
        issue(3'd1, 32'h12345678, 32'h9ABCDEF0);
        for (int n = 1; n < 10; n++) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cancel_hs got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++; $display("FAIL cancel_hilo got %h %h want %h %h", hi, lo, exp_hi, exp_lo); end
        quiet = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL cancel_quiet got done/busy after cancel want none"); end
        cancel = 1'b1;
        issue(3'd4, 32'h55555555, 32'h0);
        checks++; if (hi !== exp_hi || busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_mthi got hi=%h busy=%b want %h 0", hi, busy, exp_hi); end
        issue(3'd1, 32'h3, 32'h3);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_mul got busy=%b want 0", busy); end
    endtask
    task automatic test_reset_mid();
        bit quiet;
        issue(3'd2, 32'h80000000, 32'h3);
        for (int n = 1; n < 12; n++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo got %h %h want 0 0", hi, lo); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_hs got busy=%b done=%b want 0 0", busy, done); end
        exp_hi = '0;
        exp_lo = '0;
        quiet = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (done !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL rstmid_no_done got done pulse want none"); end
    endtask
    task automatic test_random();
        int lat;
        bit bok;
        logic [2:0] o;
        logic [31:0] x, y;
        logic [63:0] e;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            e = model(o, x, y);
            issue(o, x, y);
            if (o < 3'd4) begin
                wait_done(1, lat, bok);
                checks++; if (!lat_ok(o, lat) || !bok) begin errors++; $display("FAIL rnd%0d_timing op=%0d got lat=%0d busy_ok=%b want %0d 1", i, o, lat, bok, W + 2); end
            end else begin
                checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rnd%0d_hs op=%0d got busy=%b done=%b want 0 0", i, o, busy, done); end
            end
            checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h%h want %h", i, o, x, y, hi, lo, e); end
            {exp_hi, exp_lo} = e;
            step();
        end
    endtask
`ifdef MULDIV_EARLY_OUT_EN
    task automatic test_early_out();
        int lat;
        bit bok;
        logic [63:0] e;
        e = model(3'd1, 32'hCAFEF00D, 32'h1);
        issue(3'd1, 32'hCAFEF00D, 32'h1);
        wait_done(1, lat, bok);
        checks++; if (lat == 0 || lat > 4) begin errors++; $display("FAIL early_latency got %0d want 1..4", lat); end
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL early_result got %h%h want %h", hi, lo, e); end
        {exp_hi, exp_lo} = e;
        step();
    endtask
`endif
    initial begin
        for (int n = 0; n < 3; n++) step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_mul_div();
        test_mthi_mtlo();
        test_back_to_back();
        test_cancel();
        test_reset_mid();
        test_random();
`ifdef MULDIV_EARLY_OUT_EN
        test_early_out();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
